// File: rtl/vlc_packer.sv
// vlc_packer: packs variable-length {type_bit, value[n-1:0]} codewords MSB-first into OUT_WIDTH words.
// Defining VLC_PACKER_STAT_EN adds a 32-bit word_count output counting dout handshakes.

`ifndef THIRD_FIELD_SIZE
`define THIRD_FIELD_SIZE 8
`endif
`ifndef SEC_FIELD_SIZE
`define SEC_FIELD_SIZE 4
`endif
`ifndef TP
`define TP 1
`endif

module vlc_packer #(
    parameter int OUT_WIDTH = 16,
    parameter int TP        = `TP
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            din_valid,
    input  logic [`SEC_FIELD_SIZE+`THIRD_FIELD_SIZE:0]      data_in,
    output logic                                            din_ready,
    input  logic                                            flush,
    output logic [OUT_WIDTH-1:0]                            dout,
    output logic                                            dout_valid,
    input  logic                                            dout_ready,
`ifdef VLC_PACKER_STAT_EN
    output logic [31:0]                                     word_count,
`endif
    output logic                                            flush_done
);

    localparam int ValW  = `THIRD_FIELD_SIZE;
    localparam int NumW  = `SEC_FIELD_SIZE;
    localparam int CodeW = ValW + 1;
    localparam int AccW  = OUT_WIDTH + ValW;
    localparam int FillW = $clog2(AccW + 1);
    localparam int NeffW = $clog2(ValW + 1);
    localparam logic [FillW-1:0] OutFill = FillW'(OUT_WIDTH);

    // TP only models register delay in behavioural code; this RTL updates on the edge itself.
    if (TP < 0) begin : g_tp_unused
    end

    typedef enum logic [1:0] {
        RUN,
        FLUSH_DRAIN,
        FLUSH_EMIT
    } state_t;

    state_t               state_q, state_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic [OUT_WIDTH-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 flush_done_q, flush_done_d;

    logic                 type_bit;
    logic [NumW-1:0]      n_raw;
    logic [ValW-1:0]      value;
    logic [NeffW-1:0]     n_eff;
    logic [NeffW-1:0]     shamt;
    logic [ValW-1:0]      val_aligned;
    logic [CodeW-1:0]     code;
    logic [AccW-1:0]      code_ext;
    logic [FillW-1:0]     code_len;

    logic                 out_free;
    logic                 accept;
    logic                 emit_word;
    logic                 emit_flush;
    logic                 flush_end;

    assign type_bit = data_in[NumW+ValW];
    assign n_raw    = data_in[ValW +: NumW];
    assign value    = data_in[ValW-1:0];

    // Build the codeword left-aligned in a full accumulator-width vector.
    always_comb begin
        n_eff = NeffW'(n_raw);
        if (int'(n_raw) > ValW) begin
            n_eff = NeffW'(ValW);
        end
        shamt       = NeffW'(ValW) - n_eff;
        val_aligned = value << shamt;
        code        = {type_bit, val_aligned};
        code_ext    = {code, {(AccW - CodeW){1'b0}}};
        code_len    = FillW'(n_eff) + FillW'(1);
    end

    assign din_ready  = rst && (state_q == RUN) && (fill_q < OutFill);
    assign out_free   = !dout_valid_q || dout_ready;
    assign accept     = din_valid && din_ready;
    assign emit_word  = (fill_q >= OutFill) && out_free;
    assign emit_flush = (state_q == FLUSH_EMIT) && (fill_q != '0) && out_free;
    assign flush_end  = (state_q == FLUSH_EMIT) && ((fill_q == '0) || out_free);

    // Datapath: accumulator is MSB-aligned and every bit past fill is kept at zero.
    always_comb begin
        acc_d        = acc_q;
        fill_d       = fill_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
        if (emit_word) begin
            dout_d       = acc_q[AccW-1 -: OUT_WIDTH];
            dout_valid_d = 1'b1;
            acc_d        = acc_q << OUT_WIDTH;
            fill_d       = fill_q - OutFill;
        end else if (emit_flush) begin
            dout_d       = acc_q[AccW-1 -: OUT_WIDTH];
            dout_valid_d = 1'b1;
            acc_d        = '0;
            fill_d       = '0;
        end else if (accept) begin
            acc_d  = acc_q | (code_ext >> fill_q);
            fill_d = fill_q + code_len;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH_DRAIN;
                end
            end
            FLUSH_DRAIN: begin
                if (fill_q < OutFill) begin
                    state_d = FLUSH_EMIT;
                end
            end
            FLUSH_EMIT: begin
                if (flush_end) begin
                    flush_done_d = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign flush_done = flush_done_q;

`ifdef VLC_PACKER_STAT_EN
    logic [31:0] word_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count_q <= '0;
        end else if (dout_valid_q && dout_ready) begin
            word_count_q <= word_count_q + 32'd1;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_vlc_packer.sv
// tb_vlc_packer: directed steps with a bit-stream reference model feeding an expected-word queue.
// Build with VLC_PACKER_STAT_EN defined to also exercise word_count.

module tb_vlc_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [12:0] data_in = '0;
    logic        din_ready;
    logic        flush = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        flush_done;
`ifdef VLC_PACKER_STAT_EN
    logic [31:0] word_count;
`endif

    vlc_packer #(.OUT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .data_in    (data_in),
        .din_ready  (din_ready),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef VLC_PACKER_STAT_EN
        .word_count (word_count),
`endif
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          words_exp = 0;
    logic        bits[$];
    logic [15:0] exp_q[$];
    logic [15:0] seen[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic t, input logic [3:0] n, input logic [7:0] v);
        int          ne;
        logic [15:0] w;
        ne = (n > 4'd8) ? 8 : int'(n);
        bits.push_back(t);
        for (int i = ne - 1; i >= 0; i--) bits.push_back(v[i]);
        while (bits.size() >= 16) begin
            for (int i = 0; i < 16; i++) w[15-i] = bits.pop_front();
            exp_q.push_back(w);
            words_exp++;
        end
    endtask

    task automatic model_flush();
        logic [15:0] w;
        if (bits.size() > 0) begin
            w = '0;
            for (int i = 0; i < bits.size(); i++) w[15-i] = bits[i];
            bits.delete();
            exp_q.push_back(w);
            words_exp++;
        end
    endtask

    // Inputs are driven at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic t, input logic [3:0] n, input logic [7:0] v);
        int k;
        k = 0;
        din_valid = 1'b1;
        data_in   = {t, n, v};
        @(negedge clk);
        while (!din_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            check("send_timeout", 32'(k), 32'd0);
            din_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            model_push(t, n, v);
        end
    endtask

    task automatic do_flush();
        int start;
        int k;
        start = done_cnt;
        k = 0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
        while (done_cnt == start && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("flush_done", 32'(done_cnt), 32'(start + 1));
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every output handshake pops one expected word.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {16'd0, dout}, 32'hFFFF_FFFF);
            end else begin
                check("word", {16'd0, dout}, {16'd0, exp_q.pop_front()});
            end
            seen.push_back(dout);
        end
        if (flush_done) done_cnt++;
    end

    initial begin
        int      t0;
        int      start;
        logic [15:0] held;

        // Reset state
        #2;
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_din_ready", {31'd0, din_ready}, 32'd1);

        // Four {1,3,5}: 0xDDDD one cycle after the fourth accept
        for (int i = 0; i < 4; i++) send(1'b1, 4'd3, 8'h05);
        check("full_stall_din_ready", {31'd0, din_ready}, 32'd0);
        check("latency_not_yet", {31'd0, dout_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {31'd0, dout_valid}, 32'd1);
        check("dddd_word", {16'd0, dout}, 32'h0000_DDDD);
        do_flush();
        wait_drain();

        // Two {1,8,AB} then flush: 0xD5EA, 0xC000
        send(1'b1, 4'd8, 8'hAB);
        send(1'b1, 4'd8, 8'hAB);
        do_flush();
        wait_drain();
        check("d5ea", {16'd0, seen[seen.size()-2]}, 32'h0000_D5EA);
        check("c000", {16'd0, seen[seen.size()-1]}, 32'h0000_C000);

        // Sixteen single-bit codewords, then {0,2,3} flushed
        for (int i = 0; i < 16; i++) send(1'b1, 4'd0, 8'($urandom_range(0, 255)));
        send(1'b0, 4'd2, 8'h03);
        do_flush();
        wait_drain();
        check("ffff", {16'd0, seen[seen.size()-2]}, 32'h0000_FFFF);
        check("6000", {16'd0, seen[seen.size()-1]}, 32'h0000_6000);

        // n above the field size is clamped to 8
        send(1'b0, 4'd15, 8'h5A);
        send(1'b1, 4'd12, 8'hC3);
        do_flush();
        wait_drain();
        check("clamp_w0", {16'd0, seen[seen.size()-2]}, 32'h0000_2D70);
        check("clamp_w1", {16'd0, seen[seen.size()-1]}, 32'h0000_C000);

        // Back-pressure with 40 bits offered
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 4'd8, 8'(8'h11 * (i + 1)));
        held = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("bp_din_ready", {31'd0, din_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, dout_valid}, 32'd1);
            check("bp_hold_dout", {16'd0, dout}, {16'd0, held});
        end
        dout_ready = 1'b1;
        send(1'b0, 4'd3, 8'h07);
        do_flush();
        wait_drain();

        // Sustained input: one stall cycle per emitted word
        t0 = int'($time);
        for (int i = 0; i < 8; i++) send(1'b1, 4'd7, 8'($urandom_range(0, 255)));
        check("throughput_cycles", 32'((int'($time) - t0) / 10), 32'd11);
        do_flush();
        wait_drain();

        // Flush while not in RUN is ignored
        dout_ready = 1'b0;
        send(1'b1, 4'd8, 8'hAB);
        send(1'b1, 4'd8, 8'hAB);
        start = done_cnt;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("ignored_no_done", 32'(done_cnt), 32'(start));
        dout_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("ignored_one_done", 32'(done_cnt), 32'(start + 1));
        wait_drain();

        // Random codewords
        for (int i = 0; i < 30; i++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        do_flush();
        wait_drain();

`ifdef VLC_PACKER_STAT_EN
        check("word_count", word_count, 32'(words_exp));
`endif

        // Asynchronous reset after 9 bits discards them
        send(1'b1, 4'd8, 8'hAB);
        #2;
        rst = 1'b0;
        #1;
        check("async_dout", {16'd0, dout}, 32'd0);
        check("async_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("async_flush_done", {31'd0, flush_done}, 32'd0);
        check("async_din_ready", {31'd0, din_ready}, 32'd0);
`ifdef VLC_PACKER_STAT_EN
        check("async_word_count", word_count, 32'd0);
`endif
        bits.delete();
        words_exp = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rerun_din_ready", {31'd0, din_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_flush();
        wait_drain();

`ifdef VLC_PACKER_STAT_EN
        for (int i = 0; i < 6; i++) send(1'b1, 4'd7, 8'h3C);
        wait_drain();
        check("word_count_three", word_count, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
